// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared core package: AXI arbiter FSM states and AXI4 field encodings.
package ysyx_22040632_riscv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'd0;
  localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'd1;
  localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
  localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;

endpackage

// File: rtl/ysyx_22040632_arb_req.sv
// Requester-side bus between a cache and the AXI arbiter: one burst request
// plus its write-data, read-data and write-response streams.
interface ysyx_22040632_arb_req #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
);
  logic                valid;
  logic                ready;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    len;
  logic [2:0]          size;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rlast;
  logic [1:0]          rresp;
  logic                bvalid;
  logic [1:0]          bresp;

  modport arb (
    input  valid, we, addr, len, size, wdata, wstrb, wvalid,
    output ready, wready, rdata, rvalid, rlast, rresp, bvalid, bresp
  );

  modport master (
    output valid, we, addr, len, size, wdata, wstrb, wvalid,
    input  ready, wready, rdata, rvalid, rlast, rresp, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_22040632_axi.sv
// AXI4 bus subset used by the core: AR, R, AW, W and B channels.
interface ysyx_22040632_axi #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]    arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ysyx_22040632_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that did not win last time.
module ysyx_22040632_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant, // 0: bit0 (ic) won last, 1: bit1 (dc) won last
  output logic [1:0] gnt
);

  // One-hot pick, alternating on ties
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_22040632_axi_arbiter.sv
// Shares the single AXI4 master port between icache and dcache, one complete
// burst per grant, single outstanding transaction.
module ysyx_22040632_axi_arbiter
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rrst_n,
  ysyx_22040632_arb_req.arb        ic,
  ysyx_22040632_arb_req.arb        dc,
  ysyx_22040632_axi.master         axi,
  output logic                     busy,
  output logic [1:0]               grant
);

  arb_state_t        state_q;
  logic              last_dc_q;
  logic [1:0]        grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [LEN_W-1:0]  beat_cnt_q;

  logic              idle;
  logic [1:0]        pick;
  logic              w_fire;
  logic              wlast;

  assign idle   = (state_q == IDLE);
  assign wlast  = (beat_cnt_q == len_q);
  assign w_fire = (state_q == WR_DATA) & dc.wvalid & axi.wready;

  // Requests are only considered while idle, so a waiting requester sees nothing
  ysyx_22040632_rr_arb2 u_rr_arb2 (
    .req        (idle ? {dc.valid, ic.valid} : 2'b00),
    .last_grant (last_dc_q),
    .gnt        (pick)
  );

  // Transaction FSM: grant and latch request in IDLE, then run one burst
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= IDLE;
      last_dc_q  <= 1'b0;
      grant_q    <= 2'b00;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|pick) begin
            last_dc_q  <= pick[1];
            grant_q    <= pick;
            addr_q     <= pick[1] ? dc.addr : ic.addr;
            len_q      <= pick[1] ? dc.len : ic.len;
            size_q     <= pick[1] ? dc.size : ic.size;
            beat_cnt_q <= '0;
            // icache is read-only, its we is never looked at
            state_q    <= (pick[1] & dc.we) ? WR_ADDR : RD_ADDR;
          end
        end
        RD_ADDR: if (axi.arready) state_q <= RD_DATA;
        RD_DATA: begin
          // Slave's rlast ends the burst, not a local beat count
          if (axi.rvalid && axi.rlast) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        WR_ADDR: if (axi.awready) state_q <= WR_DATA;
        WR_DATA: begin
          if (w_fire) begin
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (wlast) state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = !idle;
  assign grant = grant_q;

  // AXI address channels: valid decoded from state, fields from the latches
  assign axi.arvalid = (state_q == RD_ADDR);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arid    = '0;
  assign axi.awvalid = (state_q == WR_ADDR);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awid    = '0;

  // Write data passes straight through from dcache
  assign axi.wvalid = (state_q == WR_DATA) & dc.wvalid;
  assign axi.wdata  = dc.wdata;
  assign axi.wstrb  = dc.wstrb;
  assign axi.wlast  = wlast;
  assign axi.rready = (state_q == RD_DATA);
  assign axi.bready = (state_q == WR_RESP);

  // Requester side: ready is the combinational grant, R and B forwarded to owner
  assign ic.ready  = pick[0];
  assign dc.ready  = pick[1];
  assign ic.rvalid = (state_q == RD_DATA) & grant_q[0] & axi.rvalid;
  assign dc.rvalid = (state_q == RD_DATA) & grant_q[1] & axi.rvalid;
  assign ic.rdata  = axi.rdata;
  assign dc.rdata  = axi.rdata;
  assign ic.rlast  = axi.rlast;
  assign dc.rlast  = axi.rlast;
  assign ic.rresp  = axi.rresp;
  assign dc.rresp  = axi.rresp;
  assign ic.wready = 1'b0;
  assign dc.wready = (state_q == WR_DATA) & axi.wready;
  assign ic.bvalid = 1'b0;
  assign ic.bresp  = AXI_RESP_OKAY;
  assign dc.bvalid = (state_q == WR_RESP) & axi.bvalid;
  assign dc.bresp  = axi.bresp;

  logic [DATA_W-1:0] unused_ic_wdata;
  logic              unused_misc;
  assign unused_ic_wdata = ic.wdata;
  assign unused_misc     = ^{ic.we, ic.wstrb, ic.wvalid, axi.rid, axi.bid};

endmodule

// File: tb/tb_ysyx_22040632_axi_arbiter.sv
// Directed bench for the AXI arbiter; R beats and B responses go through a
// scoreboard queue filled when the slave drives them.
module tb_ysyx_22040632_axi_arbiter;
  import ysyx_22040632_riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rrst_n;
  logic       busy;
  logic [1:0] grant;

  always #5 clk = ~clk;

  ysyx_22040632_arb_req ic_if ();
  ysyx_22040632_arb_req dc_if ();
  ysyx_22040632_axi     axi_if ();

  ysyx_22040632_axi_arbiter dut (
    .clk    (clk),
    .rrst_n (rrst_n),
    .ic     (ic_if),
    .dc     (dc_if),
    .axi    (axi_if),
    .busy   (busy),
    .grant  (grant)
  );

  typedef struct {
    logic [1:0]  owner;
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } rbeat_t;

  rbeat_t     r_q[$];
  logic [1:0] b_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks += 1;
    assert (obs === exp) passes += 1;
    else begin
      fails += 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] addr, input int b);
    return {addr ^ 32'hA5A5_0000, 32'(b) ^ 32'h0F0F_0F0F};
  endfunction

  task automatic raise(input bit is_dc, input logic we, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size);
    if (is_dc) begin
      dc_if.we = we; dc_if.addr = addr; dc_if.len = len; dc_if.size = size; dc_if.valid = 1'b1;
    end else begin
      ic_if.we = 1'b0; ic_if.addr = addr; ic_if.len = len; ic_if.size = size; ic_if.valid = 1'b1;
    end
  endtask

  // Bounded wait for the grant cycle, then drop valid after the grant edge
  task automatic wait_grant(input bit is_dc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      mid();
      seen = is_dc ? dc_if.ready : ic_if.ready;
    end
    check({tag, "_ready"}, 64'(seen), 1);
    if (seen) begin
      check({tag, "_other_ready"}, is_dc ? ic_if.ready : dc_if.ready, 0);
      check({tag, "_grant_in_idle"}, grant, 0);
      check({tag, "_no_arvalid_yet"}, axi_if.arvalid, 0);
      check({tag, "_no_awvalid_yet"}, axi_if.awvalid, 0);
    end
    tick();
    if (is_dc) dc_if.valid = 1'b0;
    else ic_if.valid = 1'b0;
  endtask

  task automatic pop_r();
    rbeat_t e;
    e = r_q.pop_front();
    check("r_owner", {dc_if.rvalid, ic_if.rvalid}, e.owner);
    check("r_data", e.owner[1] ? dc_if.rdata : ic_if.rdata, e.data);
    check("r_last", e.owner[1] ? dc_if.rlast : ic_if.rlast, e.last);
    check("r_resp", e.owner[1] ? dc_if.rresp : ic_if.rresp, e.resp);
  endtask

  task automatic send_beat(input bit is_dc, input logic [31:0] addr, input int b,
                           input logic last, input logic [1:0] resp);
    rbeat_t e;
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = beat_data(addr, b);
    axi_if.rlast  = last;
    axi_if.rresp  = resp;
    e.owner = is_dc ? 2'b10 : 2'b01;
    e.data  = beat_data(addr, b);
    e.last  = last;
    e.resp  = resp;
    r_q.push_back(e);
  endtask

  task automatic run_read(input bit is_dc, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int ar_stall, input logic [1:0] resp);
    for (int i = 0; i < ar_stall; i++) begin
      mid();
      check("ar_stall_arvalid", axi_if.arvalid, 1);
      check("ar_stall_araddr", axi_if.araddr, addr);
      check("ar_stall_arlen", axi_if.arlen, len);
      tick();
    end
    axi_if.arready = 1'b1;
    mid();
    check("arvalid", axi_if.arvalid, 1);
    check("araddr", axi_if.araddr, addr);
    check("arlen", axi_if.arlen, len);
    check("arsize", axi_if.arsize, size);
    check("arburst", axi_if.arburst, AXI_BURST_INCR);
    check("arid", axi_if.arid, 0);
    check("ar_grant", grant, is_dc ? 2'b10 : 2'b01);
    check("ar_busy", busy, 1);
    tick();
    axi_if.arready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      send_beat(is_dc, addr, b, b == int'(len), resp);
      mid();
      check("rready", axi_if.rready, 1);
      check("waiter_no_ready", {dc_if.ready, ic_if.ready}, 0);
      pop_r();
      tick();
    end
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [63:0] base, input logic [7:0] strb, input int w_stall,
                           input logic [1:0] resp);
    axi_if.awready = 1'b1;
    mid();
    check("awvalid", axi_if.awvalid, 1);
    check("awaddr", axi_if.awaddr, addr);
    check("awlen", axi_if.awlen, len);
    check("awsize", axi_if.awsize, size);
    check("awburst", axi_if.awburst, AXI_BURST_INCR);
    check("aw_no_arvalid", axi_if.arvalid, 0);
    check("aw_grant", grant, 2'b10);
    tick();
    axi_if.awready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      dc_if.wvalid = 1'b1;
      dc_if.wdata  = base + 64'(b);
      dc_if.wstrb  = strb;
      if (b == 0) begin
        for (int i = 0; i < w_stall; i++) begin
          axi_if.wready = 1'b0;
          mid();
          check("w_stall_wvalid", axi_if.wvalid, 1);
          check("w_stall_wlast", axi_if.wlast, int'(len) == 0);
          check("w_stall_wready", dc_if.wready, 0);
          tick();
        end
      end
      axi_if.wready = 1'b1;
      mid();
      check("wvalid", axi_if.wvalid, 1);
      check("wdata", axi_if.wdata, base + 64'(b));
      check("wstrb", axi_if.wstrb, strb);
      check("wlast", axi_if.wlast, b == int'(len));
      check("dc_wready", dc_if.wready, 1);
      tick();
    end
    dc_if.wvalid  = 1'b0;
    axi_if.wready = 1'b0;
    mid();
    check("bready", axi_if.bready, 1);
    check("b_wait_bvalid", dc_if.bvalid, 0);
    check("b_wait_wvalid", axi_if.wvalid, 0);
    tick();
    axi_if.bvalid = 1'b1;
    axi_if.bresp  = resp;
    b_q.push_back(resp);
    mid();
    check("dc_bvalid", dc_if.bvalid, 1);
    check("dc_bresp", dc_if.bresp, b_q.pop_front());
    check("ic_bvalid", ic_if.bvalid, 0);
    tick();
    axi_if.bvalid = 1'b0;
  endtask

  task automatic do_reset();
    ic_if.valid = 1'b0;
    dc_if.valid = 1'b0;
    rrst_n = 1'b0;
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst_n = 1'b0;
    ic_if.valid = 0; ic_if.we = 0; ic_if.addr = 0; ic_if.len = 0; ic_if.size = 0;
    ic_if.wdata = 0; ic_if.wstrb = 0; ic_if.wvalid = 0;
    dc_if.valid = 0; dc_if.we = 0; dc_if.addr = 0; dc_if.len = 0; dc_if.size = 0;
    dc_if.wdata = 0; dc_if.wstrb = 0; dc_if.wvalid = 0;
    axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0; axi_if.bresp = 0; axi_if.bid = 0;
    axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rdata = 0; axi_if.rresp = 0;
    axi_if.rlast = 0; axi_if.rid = 0;

    // Reset state
    tick();
    tick();
    mid();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_arvalid", axi_if.arvalid, 0);
    check("rst_awvalid", axi_if.awvalid, 0);
    check("rst_wvalid", axi_if.wvalid, 0);
    check("rst_rready", axi_if.rready, 0);
    check("rst_bready", axi_if.bready, 0);
    check("rst_req_ready", {dc_if.ready, ic_if.ready}, 0);
    check("rst_rvalid", {dc_if.rvalid, ic_if.rvalid}, 0);
    check("rst_dc_bvalid", dc_if.bvalid, 0);
    tick();
    rrst_n = 1'b1;
    tick();

    // icache refill, 4 beats
    raise(0, 0, 32'h8000_0000, 8'd3, AXI_SIZE_BYTES_8);
    wait_grant(0, "ic_refill");
    run_read(0, 32'h8000_0000, 8'd3, AXI_SIZE_BYTES_8, 0, AXI_RESP_OKAY);
    mid();
    check("ic_refill_busy_drop", busy, 0);
    check("ic_refill_grant_drop", grant, 0);
    check("ic_refill_rready_drop", axi_if.rready, 0);
    tick();

    // Tie right after reset: dc first, then ic after one idle cycle
    do_reset();
    raise(0, 0, 32'h8000_0040, 8'd0, AXI_SIZE_BYTES_8);
    raise(1, 0, 32'h1000_0000, 8'd1, AXI_SIZE_BYTES_8);
    wait_grant(1, "tie_dc");
    run_read(1, 32'h1000_0000, 8'd1, AXI_SIZE_BYTES_8, 0, AXI_RESP_OKAY);
    mid();
    check("tie_idle_busy", busy, 0);
    check("tie_idle_grant", grant, 0);
    check("tie_ic_ready_after_idle", ic_if.ready, 1);
    tick();
    ic_if.valid = 1'b0;
    run_read(0, 32'h8000_0040, 8'd0, AXI_SIZE_BYTES_8, 0, AXI_RESP_OKAY);
    mid();
    check("tie_ic_done_busy", busy, 0);
    tick();

    // Single-beat dc write
    raise(1, 1, 32'h1000_0100, 8'd0, AXI_SIZE_BYTES_4);
    wait_grant(1, "wr_len0");
    run_write(32'h1000_0100, 8'd0, AXI_SIZE_BYTES_4, 64'h1122_3344, 8'h0F, 0, AXI_RESP_OKAY);
    mid();
    check("wr_len0_bvalid_pulse", dc_if.bvalid, 0);
    check("wr_len0_busy", busy, 0);
    tick();

    // Two-beat write with a W stall and an error response
    raise(1, 1, 32'h1000_0200, 8'd1, AXI_SIZE_BYTES_8);
    wait_grant(1, "wr_len1");
    run_write(32'h1000_0200, 8'd1, AXI_SIZE_BYTES_8, 64'hDEAD_BEEF_0000_0010, 8'hFF, 1,
              AXI_RESP_SLVERR);
    mid();
    check("wr_len1_busy", busy, 0);
    tick();

    // AR held off for 5 cycles
    raise(0, 0, 32'h8000_1000, 8'd1, AXI_SIZE_BYTES_8);
    wait_grant(0, "ar_stall");
    run_read(0, 32'h8000_1000, 8'd1, AXI_SIZE_BYTES_8, 5, AXI_RESP_OKAY);
    mid();
    check("ar_stall_busy", busy, 0);
    tick();

    // MMIO read returning SLVERR: forwarded, no retry
    raise(1, 0, 32'h1000_0008, 8'd0, AXI_SIZE_BYTES_4);
    wait_grant(1, "mmio_err");
    run_read(1, 32'h1000_0008, 8'd0, AXI_SIZE_BYTES_4, 0, AXI_RESP_SLVERR);
    mid();
    check("mmio_err_busy", busy, 0);
    check("mmio_err_no_retry0", axi_if.arvalid, 0);
    tick();
    mid();
    check("mmio_err_no_retry1", axi_if.arvalid, 0);
    check("mmio_err_still_idle", busy, 0);
    tick();

    // Reset asserted during beat 2 of a 4-beat read
    raise(0, 0, 32'h8000_2000, 8'd3, AXI_SIZE_BYTES_8);
    wait_grant(0, "rst_mid");
    axi_if.arready = 1'b1;
    mid();
    check("rst_mid_arvalid", axi_if.arvalid, 1);
    tick();
    axi_if.arready = 1'b0;
    send_beat(0, 32'h8000_2000, 0, 1'b0, AXI_RESP_OKAY);
    mid();
    pop_r();
    tick();
    send_beat(0, 32'h8000_2000, 1, 1'b0, AXI_RESP_OKAY);
    mid();
    pop_r();
    #1;
    rrst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_grant", grant, 0);
    check("rst_mid_rready", axi_if.rready, 0);
    check("rst_mid_arvalid_low", axi_if.arvalid, 0);
    check("rst_mid_awvalid_low", axi_if.awvalid, 0);
    check("rst_mid_ic_rvalid", ic_if.rvalid, 0);
    axi_if.rvalid = 1'b0;
    tick();
    tick();
    rrst_n = 1'b1;
    raise(0, 0, 32'h8000_3000, 8'd0, AXI_SIZE_BYTES_8);
    raise(1, 0, 32'h1000_0300, 8'd0, AXI_SIZE_BYTES_8);
    wait_grant(1, "rst_mid_tie_dc");
    run_read(1, 32'h1000_0300, 8'd0, AXI_SIZE_BYTES_8, 0, AXI_RESP_OKAY);
    ic_if.valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
